apb_led_pwm: RTL and testbench
==============================

Name: apb_led_pwm

Overview:
- APB3 slave on a CoreAPB3 slot, driven by the MSS master APB through the APB3 interconnect.
- Drives one LED pin with a programmable, prescaled PWM waveform; can sit beside or replace the plain on/off LED register slave.
- PERIOD and DUTY are double-buffered: software writes land in shadow registers and take effect only at a period boundary, so there are no glitched PWM cycles.

Parameters:
- CNT_W, 16, width of the PWM counter and of the PERIOD/DUTY fields.
- PRE_W, 16, width of the prescaler counter and of the PRESCALE field.

Ports:
- PCLK  in  1  fabric clock (FAB_CLK); single clock domain.
- PRESERN  in  1  asynchronous active-low reset (M2F_RESET_N).
- PSEL  in  1  APB slot select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  32  byte address; only [4:2] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, registered.
- PREADY  out  1  tied 1 (zero wait state).
- PSLVERR  out  1  error response for the current access.
- LED  out  1  registered LED drive.

Behaviour:
- Reset: PCLK domain; PRESERN is asynchronous active-low. While asserted:
  - LED=0, PRDATA=0, PSLVERR=0.
  - CTRL=0, PERIOD shadow/active=0x00FF, DUTY shadow/active=0, PRESCALE=0.
  - Counters=0, FSM=OFF.
- Register map (offset, access):
  - 0x00 CTRL, RW: bit0 EN, bit1 INV (output polarity).
  - 0x04 PERIOD, RW: [CNT_W-1:0] shadow.
  - 0x08 DUTY, RW: [CNT_W-1:0] shadow.
  - 0x0C PRESCALE, RW: [PRE_W-1:0].
  - 0x10 STATUS, RO: bit0 LED, bit1 FSM==RUN, [31:16] pwm_cnt.
  - Unused bits read 0.
- APB:
  - A write commits on the PCLK edge where PSEL&PENABLE&PWRITE.
  - A read loads PRDATA on the edge where PSEL&~PENABLE&~PWRITE (setup phase), so data is valid during the access phase.
  - PSLVERR is combinational: PSEL&PENABLE&(unmapped offset 0x14-0x1C, or write to STATUS). Errored writes change no state.
  - Reads of PERIOD/DUTY return the shadow value.
- Prescaler: pre_cnt counts 0..PRESCALE, then returns to 0. tick=1 in the cycle pre_cnt==PRESCALE, so PRESCALE=0 gives a tick every cycle.
- FSM:
  - OFF: counters held at 0; active registers copy the shadows every cycle; LED<=INV. Goes to RUN when EN=1.
  - RUN: on each tick, pwm_cnt increments. When pwm_cnt==period_act it wraps to 0 and, in the same edge, loads period_act/duty_act from the shadows. Goes to OFF when EN=0 (effective the next cycle, counters cleared).
- Output: LED <= (pwm_cnt < duty_act) ^ INV, registered, so 1 cycle of latency after the counter.
  - duty_act=0: LED constantly INV.
  - duty_act > period_act: 100% on.
  - Duty ratio is duty/(period+1).
- Boundary cases:
  - Shadow write in the same cycle as a wrap: the old shadow value is loaded; the new value applies at the next wrap.
  - PERIOD shrunk below the current pwm_cnt: has no effect until the wrap.
  - Reset mid-period: everything returns to reset values immediately.

Optional Feature:
- Macro: LED_PWM_IRQ_EN.
- With the macro:
  - Adds output port IRQ (1 bit, reset 0).
  - Adds CTRL bit2 IE.
  - Adds STATUS bit2 WRAPF, sticky, set on every RUN-state wrap. Writing 1 to STATUS bit2 clears it; this write is the only allowed STATUS write and gives PSLVERR=0. A set on the same edge as a clear wins.
  - IRQ = WRAPF & IE, registered.
- Without the macro: no IRQ port; CTRL bit2 and STATUS bit2 read 0; any STATUS write gives PSLVERR.

Decomposition:
- Shared package led_pwm_pkg holds:
  - Offsets REG_CTRL=3'd0 … REG_STATUS=3'd4.
  - CTRL bit indices EN_B=0, INV_B=1, IE_B=2.
  - Reset constants PERIOD_RST=16'h00FF, DUTY_RST=0, PRE_RST=0.
  - FSM state typedef {OFF, RUN}.
- One sub-module, led_pwm_core: prescaler, counter, FSM, shadow load and LED flop. The top level holds APB decode and the register file.

Test Plan:
- Reset, then read all five offsets -> CTRL=0, PERIOD=0x000000FF, DUTY=0, PRESCALE=0, STATUS=0; LED=0; PSLVERR=0 on every read.
- PERIOD=9, DUTY=3, PRESCALE=0, CTRL=1 -> LED high for exactly 3 of every 10 cycles, repeating; STATUS[31:16] cycles 0..9.
- With the above running, write DUTY=7 mid-period -> current period still 3 high; the first period after the wrap has 7 high.
- DUTY=0 -> LED constantly 0. DUTY=12 with PERIOD=9 -> LED constantly 1. Set CTRL.INV -> both levels invert.
- PRESCALE=4, PERIOD=1, DUTY=1 -> 5 cycles high, 5 cycles low. Clear EN -> LED=INV next cycle and counter reads 0.
- Read 0x14, write 0x10 -> PSLVERR=1 during the access phase, no register change. With LED_PWM_IRQ_EN: IE=1, wrap -> IRQ=1; write STATUS=0x4 -> IRQ=0.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared constants and types for the APB LED PWM slave: register offsets,
// CTRL bit positions, reset values and the core FSM state type.
package led_pwm_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PERIOD   = 3'd1;
  localparam logic [2:0] REG_DUTY     = 3'd2;
  localparam logic [2:0] REG_PRESCALE = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  localparam int unsigned EN_B  = 0;
  localparam int unsigned INV_B = 1;
  localparam int unsigned IE_B  = 2;

  localparam logic [15:0] PERIOD_RST = 16'h00FF;
  localparam logic [15:0] DUTY_RST   = 16'h0000;
  localparam logic [15:0] PRE_RST    = 16'h0000;

  typedef enum logic {StOff, StRun} pwm_state_e;

endpackage

// File: rtl/led_pwm_core.sv
// PWM engine: prescaler, period counter, OFF/RUN FSM, period-boundary shadow
// load of PERIOD/DUTY and the registered LED output.
module led_pwm_core
  import led_pwm_pkg::*;
#(
  parameter int unsigned CntW = 16,
  parameter int unsigned PreW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            inv_i,
  input  logic [CntW-1:0] period_sh_i,
  input  logic [CntW-1:0] duty_sh_i,
  input  logic [PreW-1:0] prescale_i,
  output logic            led_o,
  output logic            run_o,
  output logic [CntW-1:0] pwm_cnt_o,
  output logic            wrap_o
);

  pwm_state_e      state_q, state_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic [CntW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CntW-1:0] period_act_q, period_act_d;
  logic [CntW-1:0] duty_act_q, duty_act_d;
  logic            led_q, led_d;
  logic            tick;

  // >= rather than == so a PRESCALE shrunk below pre_cnt ticks at once
  // instead of running the counter all the way round.
  assign tick = (pre_cnt_q >= prescale_i);

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    pwm_cnt_d    = pwm_cnt_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    led_d        = led_q;
    wrap_o       = 1'b0;
    if (state_q == StOff || !en_i) begin
      state_d   = en_i ? StRun : StOff;
      pre_cnt_d = '0;
      pwm_cnt_d = '0;
      led_d     = inv_i;
      if (state_q == StOff) begin
        period_act_d = period_sh_i;
        duty_act_d   = duty_sh_i;
      end
    end else begin
      led_d = (pwm_cnt_q < duty_act_q) ^ inv_i;
      if (tick) begin
        pre_cnt_d = '0;
        if (pwm_cnt_q == period_act_q) begin
          pwm_cnt_d    = '0;
          period_act_d = period_sh_i;
          duty_act_d   = duty_sh_i;
          wrap_o       = 1'b1;
        end else begin
          pwm_cnt_d = pwm_cnt_q + CntW'(1);
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PreW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StOff;
      pre_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      period_act_q <= CntW'(PERIOD_RST);
      duty_act_q   <= CntW'(DUTY_RST);
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      led_q        <= led_d;
    end
  end

  assign led_o     = led_q;
  assign run_o     = (state_q == StRun);
  assign pwm_cnt_o = pwm_cnt_q;

endmodule

// File: rtl/apb_led_pwm.sv
// APB3 LED PWM slave: register file and APB decode around led_pwm_core.
// Define LED_PWM_IRQ_EN to add the sticky wrap flag, CTRL.IE and the IRQ port.
module apb_led_pwm
  import led_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 16
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        LED
`ifdef LED_PWM_IRQ_EN
  ,
  output logic        IRQ
`endif
);

`ifdef LED_PWM_IRQ_EN
  localparam logic [2:0] CtrlMask = 3'b111;
`else
  localparam logic [2:0] CtrlMask = 3'b011;
`endif

  logic [2:0]       addr;
  logic             wr_en, rd_setup, unmapped, status_wr_bad;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] period_q, period_d, duty_q, duty_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [31:0]      prdata_q, prdata_d, rdata;
  logic             led, run, wrap;
  logic [CNT_W-1:0] pwm_cnt;
  logic             wrapf_q, wrapf_d;
  logic             unused_bus;

  assign addr       = PADDR[4:2];
  assign unused_bus = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};

  // Only a write of 1 to WRAPF is a legal STATUS write, and only with the IRQ option.
`ifdef LED_PWM_IRQ_EN
  assign status_wr_bad = (addr == REG_STATUS) & PWRITE & ~PWDATA[2];
`else
  assign status_wr_bad = (addr == REG_STATUS) & PWRITE;
`endif
  assign unmapped = (addr > REG_STATUS);
  assign PSLVERR  = PSEL & PENABLE & (unmapped | status_wr_bad);
  assign PREADY   = 1'b1;
  assign wr_en    = PSEL & PENABLE & PWRITE & ~PSLVERR;
  assign rd_setup = PSEL & ~PENABLE & ~PWRITE;

  always_comb begin
    rdata = '0;
    unique case (addr)
      REG_CTRL:     rdata[2:0] = ctrl_q;
      REG_PERIOD:   rdata = 32'(period_q);
      REG_DUTY:     rdata = 32'(duty_q);
      REG_PRESCALE: rdata = 32'(pre_q);
      REG_STATUS: begin
        rdata[31:16] = 16'(pwm_cnt);
        rdata[2]     = wrapf_q;
        rdata[1]     = run;
        rdata[0]     = led;
      end
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    duty_d   = duty_q;
    pre_d    = pre_q;
    wrapf_d  = wrapf_q;
    prdata_d = rd_setup ? rdata : prdata_q;
    if (wr_en) begin
      unique case (addr)
        REG_CTRL:     ctrl_d = PWDATA[2:0] & CtrlMask;
        REG_PERIOD:   period_d = PWDATA[CNT_W-1:0];
        REG_DUTY:     duty_d = PWDATA[CNT_W-1:0];
        REG_PRESCALE: pre_d = PWDATA[PRE_W-1:0];
        REG_STATUS:   if (PWDATA[2]) wrapf_d = 1'b0;
        default:      ;
      endcase
    end
`ifdef LED_PWM_IRQ_EN
    if (wrap) wrapf_d = 1'b1;
`else
    wrapf_d = 1'b0;
`endif
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ctrl_q   <= '0;
      period_q <= CNT_W'(PERIOD_RST);
      duty_q   <= CNT_W'(DUTY_RST);
      pre_q    <= PRE_W'(PRE_RST);
      prdata_q <= '0;
      wrapf_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      pre_q    <= pre_d;
      prdata_q <= prdata_d;
      wrapf_q  <= wrapf_d;
    end
  end

`ifdef LED_PWM_IRQ_EN
  logic irq_q;
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) irq_q <= 1'b0;
    else          irq_q <= wrapf_q & ctrl_q[IE_B];
  end
  assign IRQ = irq_q;
`endif

  assign PRDATA = prdata_q;
  assign LED    = led;

  led_pwm_core #(
    .CntW (CNT_W),
    .PreW (PRE_W)
  ) u_core (
    .clk_i       (PCLK),
    .rst_ni      (PRESERN),
    .en_i        (ctrl_q[EN_B]),
    .inv_i       (ctrl_q[INV_B]),
    .period_sh_i (period_q),
    .duty_sh_i   (duty_q),
    .prescale_i  (pre_q),
    .led_o       (led),
    .run_o       (run),
    .pwm_cnt_o   (pwm_cnt),
    .wrap_o      (wrap)
  );

endmodule

// File: tb/tb_apb_led_pwm.sv
// Directed bench for apb_led_pwm: register reset values, PWM waveform shapes,
// shadow-load timing, enable/disable, APB error responses and optional IRQ.
module tb_apb_led_pwm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, led;
`ifdef LED_PWM_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_led_pwm dut (
    .PCLK    (clk),
    .PRESERN (rst_n),
    .PSEL    (psel),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .PSLVERR (pslverr),
    .LED     (led)
`ifdef LED_PWM_IRQ_EN
    ,
    .IRQ     (irq)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d   = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
    check("write_ok_pslverr", {31'b0, e}, 32'd0);
  endtask

  // Wait until LED is sampled at the given level; consumes that sample.
  task automatic wait_level(input logic lvl);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (led == lvl) return;
    end
    check("wait_level_timeout", 32'd1, 32'd0);
  endtask

  // The current sample already equals lvl; counts the run, consuming the first opposite sample.
  task automatic run_len(input logic lvl, output int n);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (led != lvl) return;
      n++;
    end
  endtask

  task automatic count_high(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (led) n++;
    end
  endtask

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] period;
    logic [31:0] duty;
    logic [31:0] pre;
    int          exp_hi;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    logic [31:0] rd, s0, s1;
    logic        e;
    int          n, c0, c1;
    logic [31:0] rst_exp[5];

    tbl[0] = '{32'h1, 32'd9, 32'd3,  32'd0, 6};
    tbl[1] = '{32'h1, 32'd9, 32'd0,  32'd0, 0};
    tbl[2] = '{32'h1, 32'd9, 32'd12, 32'd0, 20};
    tbl[3] = '{32'h3, 32'd9, 32'd12, 32'd0, 0};
    tbl[4] = '{32'h3, 32'd9, 32'd0,  32'd0, 20};
    tbl[5] = '{32'h3, 32'd9, 32'd3,  32'd0, 14};
    tbl[6] = '{32'h1, 32'd1, 32'd1,  32'd4, 10};
    rst_exp = '{32'h0, 32'h0000_00FF, 32'h0, 32'h0, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_led", {31'b0, led}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apb_read(32'(i * 4), rd, e);
      check($sformatf("rst_read_%0d", i), rd, rst_exp[i]);
      check($sformatf("rst_read_err_%0d", i), {31'b0, e}, 32'd0);
    end
    check("rst_led_after", {31'b0, led}, 32'd0);

    // 3/10 waveform, counter stepping
    wr(32'h04, 32'd9);
    wr(32'h08, 32'd3);
    wr(32'h0C, 32'd0);
    wr(32'h00, 32'd1);
    repeat (30) @(negedge clk);
    apb_read(32'h10, s0, e);
    apb_read(32'h10, s1, e);
    c0 = int'(s0[31:16]);
    c1 = int'(s1[31:16]);
    check("cnt_range", {31'b0, (c0 <= 9 && c1 <= 9)}, 32'd1);
    check("cnt_step", 32'((c1 + 10 - c0) % 10), 32'd3);
    check("status_run", s0 & 32'h2, 32'h2);

    wait_level(1'b0);
    wait_level(1'b1);
    run_len(1'b1, n); check("duty3_high", 32'(n), 32'd3);
    run_len(1'b0, n); check("duty3_low", 32'(n), 32'd7);
    // Now at a rising edge: change DUTY mid-period
    wr(32'h08, 32'd7);
    wait_level(1'b0);
    run_len(1'b0, n); check("old_period_low", 32'(n), 32'd7);
    run_len(1'b1, n); check("new_duty_high", 32'(n), 32'd7);
    run_len(1'b0, n); check("new_duty_low", 32'(n), 32'd3);

    // Table of steady-state waveforms
    for (int i = 0; i < 7; i++) begin
      wr(32'h0C, tbl[i].pre);
      wr(32'h04, tbl[i].period);
      wr(32'h08, tbl[i].duty);
      wr(32'h00, tbl[i].ctrl);
      repeat (80) @(negedge clk);
      count_high(20, n);
      check($sformatf("tbl_%0d_high", i), 32'(n), 32'(tbl[i].exp_hi));
    end

    // Prescaled 5/5 waveform
    wait_level(1'b0);
    wait_level(1'b1);
    run_len(1'b1, n); check("pre_high", 32'(n), 32'd5);
    run_len(1'b0, n); check("pre_low", 32'(n), 32'd5);

    // Disable: LED goes to INV one cycle after the write, counter cleared
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd0);
    repeat (20) @(negedge clk);
    wr(32'h00, 32'h2);
    @(negedge clk);
    check("dis_led_same", {31'b0, led}, 32'd0);
    @(negedge clk);
    check("dis_led_inv", {31'b0, led}, 32'd1);
    apb_read(32'h10, rd, e);
    check("dis_status", rd & 32'hFFFF_FFFB, 32'h1);

    // Error responses
    apb_read(32'h14, rd, e);
    check("rd_unmapped_err", {31'b0, e}, 32'd1);
    check("rd_unmapped_data", rd, 32'd0);
    apb_write(32'h10, 32'h0, e);
    check("wr_status_err", {31'b0, e}, 32'd1);
    apb_write(32'h18, 32'h5, e);
    check("wr_unmapped_err", {31'b0, e}, 32'd1);
    apb_read(32'h00, rd, e);
    check("ctrl_unchanged", rd, 32'h2);
    apb_read(32'h04, rd, e);
    check("period_unchanged", rd, 32'd1);

`ifdef LED_PWM_IRQ_EN
    wr(32'h00, 32'h5);
    repeat (10) @(negedge clk);
    check("irq_set", {31'b0, irq}, 32'd1);
    wr(32'h00, 32'h4);
    repeat (5) @(negedge clk);
    check("irq_sticky", {31'b0, irq}, 32'd1);
    apb_read(32'h10, rd, e);
    check("wrapf_set", rd & 32'h4, 32'h4);
    apb_write(32'h10, 32'h4, e);
    check("wrapf_clr_err", {31'b0, e}, 32'd0);
    repeat (2) @(negedge clk);
    check("irq_clr", {31'b0, irq}, 32'd0);
    apb_read(32'h10, rd, e);
    check("wrapf_clr", rd & 32'h4, 32'h0);
`endif

    // Reset mid-period
    wr(32'h04, 32'd9);
    wr(32'h08, 32'd12);
    wr(32'h00, 32'h1);
    repeat (30) @(negedge clk);
    check("pre_reset_led", {31'b0, led}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_led", {31'b0, led}, 32'd0);
    check("midrst_prdata", prdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apb_read(32'h04, rd, e);
    check("midrst_period", rd, 32'h0000_00FF);
    apb_read(32'h00, rd, e);
    check("midrst_ctrl", rd, 32'h0);
    apb_read(32'h10, rd, e);
    check("midrst_status", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
